// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key expansion: one 32-bit schedule word per cycle, gathered into
// 128-bit round keys that are handed out in order over a valid/ready handshake.
module aes_key_schedule_seq #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [32*Nk-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [0:127]     rk_out,
    output logic [3:0]       rk_index,
    output logic             done
);

    generate
        if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_params
            $error("aes_key_schedule_seq: Nk must be 4/6/8 and Nr must equal Nk+6");
        end
    endgenerate

    localparam int         WORDS    = 4 * (Nr + 1);
    localparam logic [5:0] WORDS_W  = 6'(WORDS);
    localparam logic [2:0] K_LAST   = 3'(Nk - 1);
    localparam logic [3:0] IDX_LAST = 4'(Nr);

    // Byte 0x00 maps to the most significant entry, so lookups index with ~x.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, GEN} state_t;

    state_t      state_reg;
    logic [31:0] win_reg [Nk];
    logic [31:0] key_word [Nk];
    logic [2:0]  kmod_reg;
    logic        first_pass_reg;
    logic [5:0]  word_cnt_reg;
    logic [7:0]  rcon_reg;
    logic [1:0]  slot_reg;
    logic [0:127] rk_out_reg;
    logic [3:0]  rk_index_reg;
    logic        rk_valid_reg;
    logic        done_reg;

    logic        accept;
    logic        gen_en;
    logic [31:0] prev_word;
    logic [31:0] sub_in;
    logic [31:0] sub_word;
    logic [31:0] temp_word;
    logic [31:0] word_next;

    generate
        for (genvar gi = 0; gi < Nk; gi++) begin : g_key_word
            assign key_word[gi] = key_in[32*(Nk-gi)-1 -: 32];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
            assign sub_word[8*gi +: 8] = SBOX[~sub_in[8*gi +: 8]];
        end
    endgenerate

    assign accept    = rk_valid_reg & rk_ready;
    assign gen_en    = (state_reg == GEN) && (word_cnt_reg != WORDS_W) &&
                       !(rk_valid_reg && !rk_ready);
    assign prev_word = win_reg[Nk-1];
    assign sub_in    = (kmod_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    // During the first Nk words the window just rotates, so it is back in key
    // order (w[0] oldest) when derived words start.
    always_comb begin
        temp_word = prev_word;
        if (kmod_reg == 3'd0)
            temp_word = sub_word ^ {rcon_reg, 24'h0};
        else if (Nk == 8 && kmod_reg == 3'd4)
            temp_word = sub_word;
        word_next = first_pass_reg ? win_reg[0] : (win_reg[0] ^ temp_word);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            for (int k = 0; k < Nk; k++) win_reg[k] <= '0;
            kmod_reg       <= '0;
            first_pass_reg <= 1'b0;
            word_cnt_reg   <= '0;
            rcon_reg       <= '0;
            slot_reg       <= '0;
            rk_out_reg     <= '0;
            rk_index_reg   <= '0;
            rk_valid_reg   <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg      <= GEN;
                        for (int k = 0; k < Nk; k++) win_reg[k] <= key_word[k];
                        kmod_reg       <= '0;
                        first_pass_reg <= 1'b1;
                        word_cnt_reg   <= '0;
                        rcon_reg       <= 8'h01;
                        slot_reg       <= '0;
                        rk_index_reg   <= '0;
                    end
                end
                GEN: begin
                    if (accept) begin
                        rk_valid_reg <= 1'b0;
                        if (rk_index_reg == IDX_LAST) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            rk_index_reg <= rk_index_reg + 4'd1;
                        end
                    end
                    // A word produced in an accept cycle lands in slot 0 of the next key.
                    if (gen_en) begin
                        rk_out_reg[{slot_reg, 5'b0} +: 32] <= word_next;
                        slot_reg <= slot_reg + 2'd1;
                        if (slot_reg == 2'd3) rk_valid_reg <= 1'b1;
                        for (int k = 0; k < Nk - 1; k++) win_reg[k] <= win_reg[k+1];
                        win_reg[Nk-1] <= word_next;
                        word_cnt_reg  <= word_cnt_reg + 6'd1;
                        kmod_reg      <= (kmod_reg == K_LAST) ? 3'd0 : kmod_reg + 3'd1;
                        if (kmod_reg == K_LAST) first_pass_reg <= 1'b0;
                        if (!first_pass_reg && kmod_reg == 3'd0)
                            rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = (state_reg == GEN);
    assign rk_valid = rk_valid_reg;
    assign rk_out   = rk_out_reg;
    assign rk_index = rk_index_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for aes_key_schedule_seq: three instances (Nk=4/6/8), a behavioural
// key-expansion model feeding a scoreboard, handshake timing and reset checks.
module tb_aes_key_schedule_seq;

    typedef struct {int idx; logic [127:0] key;} exp_t;
    typedef struct {int idx; logic [127:0] key; int cycle;} got_t;

    localparam logic [255:0] K4  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K4B = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K6  = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K8  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_s [3];
    logic         ready_s [3];
    logic [255:0] key_bus [3];
    logic         busy_o [3];
    logic         valid_o [3];
    logic         done_o [3];
    logic [0:127] rk_o [3];
    logic [3:0]   idx_o [3];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    got_t got_q[$];
    got_t t1_q[$];
    logic [7:0] sbox_m [256];

    always #5 clk = ~clk;

    aes_key_schedule_seq #(.Nk(4), .Nr(10)) u_nk4 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .key_in(key_bus[0][127:0]),
        .busy(busy_o[0]), .rk_valid(valid_o[0]), .rk_ready(ready_s[0]),
        .rk_out(rk_o[0]), .rk_index(idx_o[0]), .done(done_o[0]));
    aes_key_schedule_seq #(.Nk(6), .Nr(12)) u_nk6 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .key_in(key_bus[1][191:0]),
        .busy(busy_o[1]), .rk_valid(valid_o[1]), .rk_ready(ready_s[1]),
        .rk_out(rk_o[1]), .rk_index(idx_o[1]), .done(done_o[1]));
    aes_key_schedule_seq #(.Nk(8), .Nr(14)) u_nk8 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .key_in(key_bus[2]),
        .busy(busy_o[2]), .rk_valid(valid_o[2]), .rk_ready(ready_s[2]),
        .rk_out(rk_o[2]), .rk_index(idx_o[2]), .done(done_o[2]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse plus affine map, not from a table.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] xb = 8'(x);
            for (int y = 1; y < 256; y++)
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
    endfunction

    task automatic push_expected(input int nk, input int nr, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = 32'(key >> (32 * (nk - 1 - i)));
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int j = 0; j <= nr; j++)
            exp_q.push_back('{idx: j, key: {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]}});
    endtask

    task automatic start_key(input int m, input logic [255:0] key);
        @(negedge clk);
        key_bus[m] = key;
        start_s[m] = 1'b1;
    endtask

    // Drives rk_ready and records every accepted key; the first iteration is the
    // cycle after the start edge. Observations only, comparisons are in the tests.
    task automatic collect(input int m, input int ready_pct, input int max_cycles,
                           input int stop_after, input int restart_cycle,
                           input logic [255:0] alt_key,
                           output int stab_err, output int done_cnt, output int done_cycle,
                           output int valid_cycles, output bit timed_out);
        logic [127:0] held = '0;
        int  held_idx = 0;
        bit  stalled = 1'b0;
        int  accepts = 0;
        int  tail = -1;
        got_q.delete();
        stab_err = 0; done_cnt = 0; done_cycle = -1; valid_cycles = 0; timed_out = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            start_s[m] = (c == restart_cycle);
            if (c == restart_cycle) key_bus[m] = alt_key;
            if (stalled && (!valid_o[m] || rk_o[m] !== held || int'(idx_o[m]) != held_idx))
                stab_err++;
            if (done_o[m]) begin
                done_cnt++;
                done_cycle = c;
                timed_out = 1'b0;
                if (tail < 0) tail = 3;
            end
            if (valid_o[m]) valid_cycles++;
            ready_s[m] = ($urandom_range(0, 99) < ready_pct);
            if (valid_o[m] && ready_s[m]) begin
                got_q.push_back('{idx: int'(idx_o[m]), key: rk_o[m], cycle: c});
                accepts++;
            end
            stalled  = valid_o[m] && !ready_s[m];
            held     = rk_o[m];
            held_idx = int'(idx_o[m]);
            if (stop_after > 0 && accepts == stop_after) begin
                timed_out = 1'b0;
                break;
            end
            if (tail == 0) break;
            if (tail > 0) tail--;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if ({busy_o[m], valid_o[m], done_o[m], idx_o[m], rk_o[m]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs inst %0d: got busy=%b valid=%b done=%b idx=%0d rk=%h required all 0",
                         m, busy_o[m], valid_o[m], done_o[m], idx_o[m], rk_o[m]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o[0] !== 1'b0 || valid_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b required 0 0", busy_o[0], valid_o[0]);
        end
    endtask

    task automatic test_nk4_basic();
        int se, dc, dcy, vc;
        bit to;
        exp_t e;
        start_key(0, K4);
        push_expected(4, 10, K4);
        collect(0, 100, 200, 0, -1, '0, se, dc, dcy, vc, to);
        checks++; if (to) begin errors++; $display("FAIL nk4_timeout: got no done required done"); end
        checks++; if (got_q.size() != 11) begin errors++; $display("FAIL nk4_count: got %0d required 11", got_q.size()); end
        for (int j = 0; j < got_q.size() && exp_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[j].idx != e.idx || got_q[j].key !== e.key) begin
                errors++;
                $display("FAIL nk4_key%0d: got idx=%0d %h required idx=%0d %h", j, got_q[j].idx, got_q[j].key, e.idx, e.key);
            end
            checks++;
            if (got_q[j].cycle != 4 * j + 4) begin
                errors++;
                $display("FAIL nk4_valid_cycle%0d: got %0d required %0d", j, got_q[j].cycle, 4 * j + 4);
            end
            $display("nk4 key %0d idx %0d %h cycle %0d", j, got_q[j].idx, got_q[j].key, got_q[j].cycle);
        end
        exp_q.delete();
        if (got_q.size() == 11) begin
            checks++;
            if (got_q[0].key !== K4[127:0] || got_q[1].key !== 128'ha0fafe1788542cb123a339392a6c7605 ||
                got_q[10].key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
                errors++;
                $display("FAIL nk4_known: got rk0=%h rk1=%h rk10=%h required fips values", got_q[0].key, got_q[1].key, got_q[10].key);
            end
        end
        checks++; if (vc != 11) begin errors++; $display("FAIL nk4_valid_cycles: got %0d required 11", vc); end
        checks++; if (dc != 1 || dcy != 45) begin errors++; $display("FAIL nk4_done: got count=%0d cycle=%0d required 1 at 45", dc, dcy); end
        checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL nk4_busy_end: got %b required 0", busy_o[0]); end
        t1_q = got_q;
    endtask

    task automatic test_nk6();
        int se, dc, dcy, vc;
        bit to;
        exp_t e;
        start_key(1, K6);
        push_expected(6, 12, K6);
        collect(1, 100, 200, 0, -1, '0, se, dc, dcy, vc, to);
        checks++; if (to || dc != 1) begin errors++; $display("FAIL nk6_done: got timeout=%b count=%0d required 0 1", to, dc); end
        checks++; if (got_q.size() != 13) begin errors++; $display("FAIL nk6_count: got %0d required 13", got_q.size()); end
        for (int j = 0; j < got_q.size() && exp_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[j].idx != e.idx || got_q[j].key !== e.key) begin
                errors++;
                $display("FAIL nk6_key%0d: got idx=%0d %h required idx=%0d %h", j, got_q[j].idx, got_q[j].key, e.idx, e.key);
            end
            $display("nk6 key %0d idx %0d %h cycle %0d", j, got_q[j].idx, got_q[j].key, got_q[j].cycle);
        end
        exp_q.delete();
        if (got_q.size() == 13) begin
            checks++;
            if (got_q[1].key[63:32] !== 32'hfe0c91f7 || got_q[12].key !== 128'he98ba06f448c773c8ecc720401002202) begin
                errors++;
                $display("FAIL nk6_known: got rk1w2=%h rk12=%h required fe0c91f7 e98ba06f448c773c8ecc720401002202",
                         got_q[1].key[63:32], got_q[12].key);
            end
        end
    endtask

    task automatic test_nk8();
        int se, dc, dcy, vc;
        bit to;
        exp_t e;
        start_key(2, K8);
        push_expected(8, 14, K8);
        collect(2, 100, 200, 0, -1, '0, se, dc, dcy, vc, to);
        checks++; if (to || dc != 1) begin errors++; $display("FAIL nk8_done: got timeout=%b count=%0d required 0 1", to, dc); end
        checks++; if (got_q.size() != 15) begin errors++; $display("FAIL nk8_count: got %0d required 15", got_q.size()); end
        for (int j = 0; j < got_q.size() && exp_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[j].idx != e.idx || got_q[j].key !== e.key) begin
                errors++;
                $display("FAIL nk8_key%0d: got idx=%0d %h required idx=%0d %h", j, got_q[j].idx, got_q[j].key, e.idx, e.key);
            end
            $display("nk8 key %0d idx %0d %h cycle %0d", j, got_q[j].idx, got_q[j].key, got_q[j].cycle);
        end
        exp_q.delete();
        if (got_q.size() == 15) begin
            checks++;
            if (got_q[2].key !== 128'h9ba354118e6925afa51a8b5f2067fcde || got_q[14].key !== 128'hfe4890d1e6188d0b046df344706c631e) begin
                errors++;
                $display("FAIL nk8_known: got rk2=%h rk14=%h required fips values", got_q[2].key, got_q[14].key);
            end
        end
    endtask

    task automatic test_backpressure();
        int se, dc, dcy, vc;
        bit to;
        exp_t e;
        start_key(0, K4);
        push_expected(4, 10, K4);
        collect(0, 30, 3000, 0, -1, '0, se, dc, dcy, vc, to);
        checks++; if (to || dc != 1) begin errors++; $display("FAIL bp_done: got timeout=%b count=%0d required 0 1", to, dc); end
        checks++; if (got_q.size() != 11) begin errors++; $display("FAIL bp_count: got %0d required 11", got_q.size()); end
        for (int j = 0; j < got_q.size() && exp_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[j].idx != e.idx || got_q[j].key !== e.key) begin
                errors++;
                $display("FAIL bp_key%0d: got idx=%0d %h required idx=%0d %h", j, got_q[j].idx, got_q[j].key, e.idx, e.key);
            end
            $display("bp key %0d idx %0d %h cycle %0d", j, got_q[j].idx, got_q[j].key, got_q[j].cycle);
        end
        exp_q.delete();
        checks++; if (se != 0) begin errors++; $display("FAIL bp_stable: got %0d stall violations required 0", se); end
        if (got_q.size() > 0) begin
            checks++;
            if (dcy != got_q[got_q.size()-1].cycle + 1) begin
                errors++;
                $display("FAIL bp_done_cycle: got %0d required %0d", dcy, got_q[got_q.size()-1].cycle + 1);
            end
        end
    endtask

    task automatic test_start_ignored();
        int se, dc, dcy, vc;
        bit to;
        exp_t e;
        start_key(0, K4);
        push_expected(4, 10, K4);
        collect(0, 100, 200, 0, 10, {256{1'b1}}, se, dc, dcy, vc, to);
        checks++; if (to || dc != 1 || dcy != 45) begin errors++; $display("FAIL restart_done: got timeout=%b count=%0d cycle=%0d required 0 1 45", to, dc, dcy); end
        checks++; if (got_q.size() != t1_q.size()) begin errors++; $display("FAIL restart_count: got %0d required %0d", got_q.size(), t1_q.size()); end
        for (int j = 0; j < got_q.size() && j < t1_q.size() && exp_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[j].key !== e.key || got_q[j].idx != e.idx || got_q[j].cycle != t1_q[j].cycle) begin
                errors++;
                $display("FAIL restart_key%0d: got idx=%0d %h cycle %0d required idx=%0d %h cycle %0d",
                         j, got_q[j].idx, got_q[j].key, got_q[j].cycle, e.idx, e.key, t1_q[j].cycle);
            end
            $display("restart key %0d idx %0d %h cycle %0d", j, got_q[j].idx, got_q[j].key, got_q[j].cycle);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int se, dc, dcy, vc;
        bit to;
        exp_t e;
        start_key(0, K4);
        push_expected(4, 10, K4);
        collect(0, 100, 200, 4, -1, '0, se, dc, dcy, vc, to);
        checks++; if (to || got_q.size() != 4) begin errors++; $display("FAIL rstmid_pre: got %0d keys required 4", got_q.size()); end
        for (int j = 0; j < got_q.size() && exp_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[j].idx != e.idx || got_q[j].key !== e.key) begin
                errors++;
                $display("FAIL rstmid_key%0d: got idx=%0d %h required idx=%0d %h", j, got_q[j].idx, got_q[j].key, e.idx, e.key);
            end
        end
        exp_q.delete();
        @(negedge clk);
        ready_s[0] = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (valid_o[0] !== 1'b1 || idx_o[0] !== 4'd4) begin
            errors++;
            $display("FAIL rstmid_stalled: got valid=%b idx=%0d required 1 4", valid_o[0], idx_o[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o[0], valid_o[0], done_o[0], idx_o[0], rk_o[0]} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got busy=%b valid=%b done=%b idx=%0d rk=%h required all 0",
                     busy_o[0], valid_o[0], done_o[0], idx_o[0], rk_o[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ready_s[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_pending: got valid=%b busy=%b required 0 0", valid_o[0], busy_o[0]);
        end
        start_key(0, K4B);
        push_expected(4, 10, K4B);
        collect(0, 100, 200, 0, -1, '0, se, dc, dcy, vc, to);
        checks++; if (to || dc != 1 || got_q.size() != 11) begin errors++; $display("FAIL rstmid_rerun: got keys=%0d done=%0d required 11 1", got_q.size(), dc); end
        for (int j = 0; j < got_q.size() && exp_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[j].idx != e.idx || got_q[j].key !== e.key) begin
                errors++;
                $display("FAIL rerun_key%0d: got idx=%0d %h required idx=%0d %h", j, got_q[j].idx, got_q[j].key, e.idx, e.key);
            end
            $display("rerun key %0d idx %0d %h cycle %0d", j, got_q[j].idx, got_q[j].key, got_q[j].cycle);
        end
        exp_q.delete();
        if (got_q.size() == 11) begin
            checks++;
            if (got_q[10].key !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
                errors++;
                $display("FAIL rerun_rk10: got %h required 13111d7fe3944a17f307a78b4d2b30c5", got_q[10].key);
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 3; m++) begin
            start_s[m] = 1'b0;
            ready_s[m] = 1'b1;
            key_bus[m] = '0;
        end
        build_sbox();
        test_reset();
        test_nk4_basic();
        test_nk6();
        test_nk8();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
